// File: rtl/matrix_input_collector_pkg.sv
// Shared constants and state encoding for the matrix pipeline stages.
// All stages import this package so that widths and state codes agree.
package matrix_input_collector_pkg;

    localparam int MAT_DATA_WIDTH = 9;
    localparam int MAT_MAX_DIM    = 5;
    localparam int MAT_MAX_ELEM   = 25;
    localparam int MAT_DIM_W      = 3;
    localparam int MAT_CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } mat_state_t;

endpackage

// File: rtl/matrix_input_collector_dim_check.sv
// Combinational check of a requested r x c shape.
// Produces the legality flag and the element total.
module matrix_dim_check
    import matrix_input_collector_pkg::*;
#(
    parameter int MAX_DIM = MAT_MAX_DIM
) (
    input  logic [MAT_DIM_W-1:0] r,
    input  logic [MAT_DIM_W-1:0] c,
    output logic                 valid,
    output logic [MAT_CNT_W-1:0] total
);

    localparam logic [MAT_DIM_W-1:0] LIM = MAT_DIM_W'(MAX_DIM);

    assign valid = (r != '0) && (c != '0) && (r <= LIM) && (c <= LIM);
    // 5 bits hold every legal product (max 25); illegal shapes may wrap.
    assign total = {2'b00, r} * {2'b00, c};

endmodule

// File: rtl/matrix_input_collector.sv
// Collects an r x c matrix streamed row-major into a flat 25-slot buffer
// and holds it, with done high, until the downstream stage acknowledges.
module matrix_input_collector
    import matrix_input_collector_pkg::*;
#(
    parameter int DATA_WIDTH = MAT_DATA_WIDTH,
    parameter int MAX_DIM    = MAT_MAX_DIM
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [MAT_DIM_W-1:0]               r,
    input  logic [MAT_DIM_W-1:0]               c,
    input  logic                               abort,
    input  logic                               in_valid,
    input  logic [DATA_WIDTH-1:0]              in_data,
    output logic                               in_ready,
    input  logic                               ack,
    output logic [MAT_MAX_ELEM*DATA_WIDTH-1:0] data_out,
    output logic [MAT_DIM_W-1:0]               r_out,
    output logic [MAT_DIM_W-1:0]               c_out,
    output logic [MAT_CNT_W-1:0]               count,
    output logic                               busy,
    output logic                               done,
    output logic                               err
);

    mat_state_t           r_state;
    mat_state_t           w_next_state;
    logic                 w_dim_valid;
    logic [MAT_CNT_W-1:0] w_dim_total;
    logic [MAT_DIM_W-1:0] r_rows;
    logic [MAT_DIM_W-1:0] r_cols;
    logic [MAT_CNT_W-1:0] r_total;
    logic [MAT_CNT_W-1:0] r_count;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic                 w_start_ok;
    logic                 w_start_bad;
    logic                 w_abort;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_clear;

    matrix_dim_check #(
        .MAX_DIM (MAX_DIM)
    ) u_dim_check (
        .r     (r),
        .c     (c),
        .valid (w_dim_valid),
        .total (w_dim_total)
    );

    // start is only honoured outside LOAD; abort only inside it.
    assign w_start_ok  = start && w_dim_valid && (r_state != LOAD);
    assign w_start_bad = start && !w_dim_valid && (r_state != LOAD);
    assign w_abort     = (r_state == LOAD) && abort;
    assign w_accept    = (r_state == LOAD) && in_valid && !abort;
    assign w_last      = w_accept && ((r_count + 5'd1) == r_total);
    assign w_clear     = w_start_ok || w_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_ok) w_next_state = LOAD;
            end
            LOAD: begin
                if (abort)       w_next_state = IDLE;
                else if (w_last) w_next_state = DONE;
            end
            DONE: begin
                // A start of any kind outranks ack; a rejected one keeps DONE.
                if (start) begin
                    if (w_dim_valid) w_next_state = LOAD;
                end else if (ack) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows  <= '0;
            r_cols  <= '0;
            r_total <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err  <= w_start_bad;
            r_busy <= (w_next_state == LOAD);
            r_done <= (w_next_state == DONE);
            if (w_start_ok) begin
                r_rows  <= r;
                r_cols  <= c;
                r_total <= w_dim_total;
                r_count <= '0;
            end else if (w_abort) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= r_count + 5'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAT_MAX_ELEM; gi++) begin : g_slot
            logic [DATA_WIDTH-1:0] r_slot;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_slot <= '0;
                end else if (w_clear) begin
                    r_slot <= '0;
                end else if (w_accept && (r_count == MAT_CNT_W'(gi))) begin
                    r_slot <= in_data;
                end
            end

            assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_slot;
        end
    endgenerate

    assign in_ready = (r_state == LOAD);
    assign r_out    = r_rows;
    assign c_out    = r_cols;
    assign count    = r_count;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: doc/matrix_input_collector.md
MATRIX_INPUT_COLLECTOR -- requirements
Module: matrix_input_collector

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 9, giving the element width in bits.
REQ-002 The block SHALL have parameter MAX_DIM, default 5, giving the maximum row and column count.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin collecting a matrix.
REQ-007 r  input  3  requested row count, sampled when start is accepted.
REQ-008 c  input  3  requested column count, sampled when start is accepted.
REQ-009 abort  input  1  cancels a collection in progress.
REQ-010 in_valid  input  1  in_data holds a valid element.
REQ-011 in_data  input  DATA_WIDTH  element value.
REQ-012 in_ready  output  1  block accepts an element this cycle.
REQ-013 ack  input  1  downstream has consumed the result.
REQ-014 data_out  output  25*DATA_WIDTH  packed element buffer; slot k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-015 r_out  output  3  latched row count.
REQ-016 c_out  output  3  latched column count.
REQ-017 count  output  5  number of elements accepted so far.
REQ-018 busy  output  1  high in LOAD.
REQ-019 done  output  1  high in DONE; this is the enable for the downstream reorder stage.
REQ-020 err  output  1  one-cycle pulse on a rejected start.

Function
REQ-021 The FSM SHALL have three states: IDLE, LOAD and DONE.
REQ-022 IDLE: in_ready=0.
- start with 1<=r<=MAX_DIM and 1<=c<=MAX_DIM: latch r/c, clear all 25 slots to 0, set count=0, go to LOAD next cycle.
- Any other start: err=1 for exactly one cycle; state stays IDLE; r_out/c_out are unchanged.
REQ-023 LOAD: in_ready=1 combinationally. When in_valid&&in_ready, in_data SHALL be written to slot count and count SHALL increment.
REQ-024 Elements SHALL be stored contiguously in slots 0..r*c-1 in arrival order (row-major stream). Slots r*c..24 SHALL remain 0.
REQ-025 total = r_out*c_out SHALL be computed at 5-bit width (max 25).
REQ-026 LOAD exits to DONE in the cycle after the element that makes count equal total is accepted; in_ready SHALL be 0 from that next cycle onward.
REQ-027 abort in LOAD SHALL return to IDLE next cycle, clear all slots and count to 0, and leave r_out/c_out unchanged.
REQ-028 If abort and in_valid are high in the same LOAD cycle, abort wins and the element SHALL be dropped.
REQ-029 start in LOAD SHALL be ignored; abort in IDLE or DONE SHALL be ignored.
REQ-030 DONE: done=1, in_ready=0, and data_out/r_out/c_out/count SHALL be held stable.
- ack returns to IDLE next cycle with data_out retained.
- start in DONE behaves as in IDLE (validate, clear, LOAD) and takes priority over ack.
REQ-031 in_valid outside LOAD SHALL have no effect.
REQ-032 Latency: first element may be accepted 1 cycle after start; done rises 1 cycle after the last element is accepted.
REQ-033 All outputs SHALL be registered except in_ready, which is decoded from state.

Reset
REQ-034 On rst_n low, the FSM SHALL go to IDLE immediately and asynchronously.
REQ-035 On reset, data_out, r_out, c_out, count, busy, done and err SHALL all be 0.
REQ-036 Reset mid-LOAD SHALL discard partial data. After rst_n deasserts, the first rising edge behaves as IDLE.

Structure
REQ-037 DATA_WIDTH, MAX_DIM, MAX_ELEM=25 and the state encodings (IDLE=2'd0, LOAD=2'd1, DONE=2'd2) SHALL live in the shared matrix package header used by all matrix stages.
REQ-038 Dimension validation SHALL be a separate combinational sub-module, matrix_dim_check (inputs r, c; outputs valid and total). No other sub-modules.

Verification
REQ-039 Normal load: start r=2 c=3, stream 1..6 back-to-back -> done after 6 accepts; slots 0..5 = 1..6, slots 6..24 = 0, count=6.
REQ-040 Illegal dimensions: start r=0 c=3, then r=6 c=2 -> err pulses one cycle each; state stays IDLE; in_ready stays 0.
REQ-041 Gapped stream with abort: r=5 c=5, in_valid toggling, abort after 10 elements asserted together with in_valid -> 11th element dropped; IDLE; data_out all 0.
REQ-042 Full matrix and restart: r=5 c=5, 25 elements 0x1FF..0x1E7; in_valid held high extra cycles -> exactly 25 accepted. Then start r=1 c=1 in DONE -> buffer cleared, LOAD entered.
REQ-043 Async reset: assert rst_n low mid-LOAD between clock edges -> all outputs 0 without waiting for a clock edge; after release, a 1x1 load completes correctly.
